// File: rtl/irq_ctl.sv
// Eight-source edge-triggered interrupt controller for the AVR core.
// Firmware programs it through mask, pending, control and end-of-interrupt registers.
module irq_ctl #(
  parameter logic [15:0] MASK_ADDR = 16'h0058,
  parameter logic [15:0] PEND_ADDR = 16'h0059,
  parameter logic [15:0] CTRL_ADDR = 16'h005A,
  parameter logic [15:0] EOI_ADDR  = 16'h005B,
  parameter int          HOLD_CYC  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] a,
  input  logic [7:0]  o,
  input  logic        w,
  input  logic        r,
  input  logic [7:0]  src,
  output logic [7:0]  q,
  output logic        sel,
  output logic        intr,
  output logic [2:0]  vect
);

  localparam int CNT_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t             state, state_n;
  logic [7:0]         sync_p0, sync_p1, hist_p2;
  logic [7:0]         pend, mask, cand, rise, clr;
  logic               gie, isv, start, done;
  logic [2:0]         cur;
  logic [CNT_W-1:0]   cnt;
  logic               mask_wr, pend_wr, ctrl_wr, eoi_wr;
  logic               unused_rd;

  function automatic logic [2:0] lowest_idx(input logic [7:0] c);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (c[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Reads are side-effect free; the strobe is only carried for bus symmetry.
  assign unused_rd = r;

  assign mask_wr = w && (a == MASK_ADDR);
  assign pend_wr = w && (a == PEND_ADDR);
  assign ctrl_wr = w && (a == CTRL_ADDR);
  assign eoi_wr  = w && (a == EOI_ADDR);

  assign rise = sync_p1 & ~hist_p2;
  assign cand = pend & mask;
  assign clr  = (pend_wr ? o : 8'h00) | (done ? (8'h01 << cur) : 8'h00);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gie && (cand != 8'h00)) state_n = REQ;
      REQ:     if (cnt == '0) state_n = SERV;
      SERV:    if (eoi_wr) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    intr  = (state == REQ);
    isv   = (state == SERV);
    start = (state == IDLE) && (state_n == REQ);
    done  = (state == REQ) && (cnt == '0);
  end

  // Stage p0/p1: two-flop synchronizer; p2: edge history. A same-cycle edge beats any clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 8'h00;
      sync_p1 <= 8'h00;
      hist_p2 <= 8'h00;
      pend    <= 8'h00;
      mask    <= 8'h00;
      gie     <= 1'b0;
      cur     <= 3'd0;
      cnt     <= '0;
    end else begin
      sync_p0 <= src;
      sync_p1 <= sync_p0;
      hist_p2 <= sync_p1;
      pend    <= (pend & ~clr) | rise;
      if (mask_wr) mask <= o;
      if (ctrl_wr) gie <= o[0];
      if (start) begin
        cur <= lowest_idx(cand);
        cnt <= CNT_W'(HOLD_CYC - 1);
      end else if (state == REQ && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign vect = cur;

  always_comb begin
    q   = 8'h00;
    sel = 1'b1;
    if      (a == MASK_ADDR) q = mask;
    else if (a == PEND_ADDR) q = pend;
    else if (a == CTRL_ADDR) q = {isv, 1'b0, cur, 2'b00, gie};
    else if (a == EOI_ADDR)  q = 8'h00;
    else                     sel = 1'b0;
  end

endmodule
